// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns / InvMixColumns engine, transforming COLS_PER_CYCLE
// columns per busy cycle in place, with valid/ready handshakes on both sides.
module mix_columns_iter #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_op,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  // state | meaning
  // IDLE  | waiting for an input block
  // BUSY  | transforming columns of the captured block
  // DONE  | result presented until consumed
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // With four columns per cycle the step wraps to 0, which keeps the counter at 0.
  localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);

  state_t       state, state_next;
  logic [1:0]   col_cnt;
  logic [1:0]   col_idx;
  logic [127:0] st_reg;
  logic [127:0] st_mixed;
  logic         op_reg;
  logic         accept;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic enc);
    logic [7:0] a  [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m  [4];
    for (int j = 0; j < 4; j++) begin
      a[j]  = col[31-8*j -: 8];
      x2[j] = xt(a[j]);
      x4[j] = xt(x2[j]);
      x8[j] = xt(x4[j]);
    end
    for (int r = 0; r < 4; r++) begin
      if (enc)
        m[r] = x2[r] ^ (x2[(r+1)%4] ^ a[(r+1)%4]) ^ a[(r+2)%4] ^ a[(r+3)%4];
      else
        m[r] = (x8[r] ^ x4[r] ^ x2[r])
             ^ (x8[(r+1)%4] ^ x2[(r+1)%4] ^ a[(r+1)%4])
             ^ (x8[(r+2)%4] ^ x4[(r+2)%4] ^ a[(r+2)%4])
             ^ (x8[(r+3)%4] ^ a[(r+3)%4]);
    end
    return {m[0], m[1], m[2], m[3]};
  endfunction

  always_comb begin
    st_mixed = st_reg;
    col_idx  = '0;
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      col_idx = col_cnt + 2'(k);
      st_mixed[127-32*col_idx -: 32] = mix_col(st_reg[127-32*col_idx -: 32], op_reg);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (col_cnt == LAST) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_next = in_valid ? BUSY : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept   = in_valid && in_ready;
  assign out_data = st_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_reg  <= '0;
      op_reg  <= 1'b0;
      col_cnt <= '0;
    end else if (accept) begin
      st_reg  <= in_data;
      op_reg  <= in_op;
      col_cnt <= '0;
    end else if (state == BUSY) begin
      st_reg  <= st_mixed;
      col_cnt <= col_cnt + STEP;
    end
  end

endmodule

// File: doc/mix_columns_iter.md
MIX_COLUMNS_ITER -- requirements
Module: mix_columns_iter

Interface
REQ-001 The block SHALL have parameter COLS_PER_CYCLE, default 1, giving the AES columns transformed per busy cycle; legal values are 1, 2 and 4.
REQ-002 The block SHALL elaborate-time error on any other COLS_PER_CYCLE value.
REQ-003 Port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port in_valid  input  1  input block present.
REQ-006 Port in_ready  output  1  block can accept input this cycle.
REQ-007 Port in_op  input  1  mode: 1 = MixColumns (encrypt), 0 = InvMixColumns (decrypt).
REQ-008 Port in_data  input  128  AES state; byte i = in_data[127-8i -: 8]; column c = bytes 4c..4c+3, with byte 4c as row 0.
REQ-009 Port out_valid  output  1  result present.
REQ-010 Port out_ready  input  1  consumer accepts the result.
REQ-011 Port out_data  output  128  transformed state, same byte order as in_data.
REQ-012 Port busy  output  1  high while in state BUSY.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-014 Input SHALL be accepted on a rising edge where in_valid and in_ready are both high; in_data and in_op SHALL be captured into an internal 128-bit state register and op register on that edge.
REQ-015 in_ready SHALL be high in IDLE, low in BUSY, and equal to out_ready in DONE (combinational path from out_ready).
REQ-016 On accept, the FSM SHALL go to BUSY and clear the column counter to 0.
REQ-017 Each BUSY cycle SHALL transform columns counter..counter+COLS_PER_CYCLE-1 in place, then advance the counter by COLS_PER_CYCLE.
REQ-018 The transform SHALL use the captured op, not the live in_op; changes to in_data and in_op during BUSY SHALL have no effect.
REQ-019 After the edge that processes column 3, the FSM SHALL be in DONE.
REQ-020 out_valid SHALL rise exactly N = 4/COLS_PER_CYCLE cycles after the accept edge, giving latency 4, 2 or 1.
REQ-021 Encrypt SHALL multiply each column by GF(2^8) matrix rows [02 03 01 01] circularly rotated, with polynomial 0x11B.
REQ-022 Decrypt SHALL multiply each column by rows [0E 0B 0D 09] circularly rotated, with polynomial 0x11B.
REQ-023 out_valid SHALL be high only in DONE; out_data SHALL equal the state register and SHALL hold stable while out_valid is high and out_ready is low.
REQ-024 In DONE with out_ready high and in_valid low, the FSM SHALL go to IDLE on the edge and out_valid SHALL drop.
REQ-025 In DONE with out_ready and in_valid both high, the result SHALL be consumed and the new block accepted on the same edge (state goes to BUSY), so there are no bubble cycles between blocks.
REQ-026 in_valid high while in BUSY SHALL be ignored; the upstream holds its data until in_ready is high.
REQ-027 busy SHALL be high iff the state is BUSY.
REQ-028 Throughput SHALL be one block per N+1 cycles with out_ready held high and continuous in_valid.

Reset
REQ-029 While rst_n is low, state SHALL be IDLE, the counter 0, the state register 0 and the op register 0.
REQ-030 While rst_n is low, out_valid and busy SHALL be 0, out_data SHALL be 0, and in_ready SHALL be 1.
REQ-031 Reset assertion in BUSY or DONE SHALL abort the operation immediately (asynchronously); no partial result SHALL be presented after release.
REQ-032 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-033 Encrypt, COLS_PER_CYCLE=1: in_data=128'hdb135345_f20a225c_01010101_c6c6c6c6, in_op=1 -> out_data=128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, with out_valid exactly 4 cycles after accept.
REQ-034 Decrypt, COLS_PER_CYCLE=1, 2 and 4: in_data=128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8, in_op=0 -> out_data=128'hdb135345_f20a225c_d4d4d4d5_2d26314c, with latency 4, 2 and 1 respectively.
REQ-035 Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, out_data is unchanged, and in_ready=0 throughout; when out_ready=1, the result is consumed and the FSM goes to IDLE.
REQ-036 Back-to-back: in_valid held high, out_ready=1, alternating in_op -> each result matches the golden model, with one accept every N+1 cycles and no gaps.
REQ-037 Mid-operation abort: assert rst_n=0 in the second BUSY cycle -> out_valid=0, out_data=0 and in_ready=1 immediately; a subsequent encrypt of the REQ-033 vector gives the correct result.
REQ-038 Input change during BUSY: toggle in_op and in_data to all-ones after accept -> the result still matches the captured block.
